e_digit_streamer: RTL and testbench
===================================

// Module: e_digit_streamer
// PURPOSE
//  Consumer of the wide fixed-point e result: captures the 16*WORDS-bit value when the calculator's done pulses.
//  Converts it to a decimal ASCII character stream "I.ddd...d" over a valid/ready byte interface.
//  Sits between the e calculator and the UART/host byte sink.
//  Fraction digits come from word-serial multiply-by-10: one 16-bit word per cycle, LSW first.
// PARAMETERS
//  WORDS    32   16-bit words in in_data; top word = integer part, lower WORDS-1 words = binary fraction
//  NDIGITS  150  fraction digits emitted per value (>=1; digits beyond 16*(WORDS-1)*log10(2) are not exact)
// PORTS
//  clk        in   1           single clock, all logic on rising edge
//  rst        in   1           synchronous, active-high reset
//  in_valid   in   1           value present (driven by calculator done); sampled only while in_ready=1
//  in_data    in   16*WORDS    fixed-point value, word 0 = bits[15:0] = least significant
//  in_ready   out  1           high in IDLE only
//  dout       out  8           ASCII character
//  dout_valid out  1           character valid
//  dout_ready in   1           sink accepts when dout_valid&&dout_ready (handshake)
//  dout_last  out  1           high with the final character of the stream
//  busy       out  1           ~in_ready
// BEHAVIOUR
//  Reset: state=IDLE; in_ready=1, dout=8'h00, dout_valid=0, dout_last=0, busy=0; fraction regs, counters cleared.
//  FSM states: IDLE, INT, DOT, MUL, EMIT (+CR, LF when enabled); clock and reset as stated in PORTS.
//  IDLE: in_valid=1 -> latch integer word and WORDS-1 fraction words; digit cnt=0; -> INT next cycle.
//  INT: dout_valid=1; dout = 8'h30+int if int<=9, else 8'h3F '?'. On handshake -> DOT.
//  DOT: dout=8'h2E '.'. On handshake -> MUL with word idx=0, carry=0.
//  MUL: one word per cycle, WORDS-1 cycles. p[19:0]=frac[idx]*10+carry; frac[idx]<=p[15:0]; carry<=p[19:16].
//   carry is always 0..9; after idx=WORDS-2 -> EMIT. dout_valid=0 throughout MUL.
//  EMIT: dout=8'h30+carry, dout_valid=1, cnt increments on handshake.
//   On handshake: cnt==NDIGITS-1 -> IDLE (or CR when enabled), else -> MUL (idx=0, carry=0).
//  Latency: in_valid accept -> first char valid 1 cycle later.
//   Each fraction char is valid WORDS-1 cycles after MUL entry, i.e. WORDS cycles after the previous handshake.
//  Stream rule: while dout_valid&&!dout_ready, dout/dout_last hold stable and no state advances.
//   dout_valid never drops without a handshake.
//  dout_last=1 only on the final char: last digit, or LF when enabled. Returning to IDLE drops dout_valid next cycle.
//  in_valid while busy: ignored and not queued; latched value unaffected.
//  in_valid and final handshake in same cycle: not accepted (in_ready=0 that cycle); accepted next cycle if still high.
//  All-zero fraction: emits NDIGITS '0'. Max fraction (all ones): no overflow, digits '9' until exhausted.
//  Integer word>9: '?' only; fraction still emitted normally.
//  Reset mid-stream (any state): returns to reset values next edge; partial stream abandoned, no dout_last.
//  Widths: idx $clog2(WORDS) bits, cnt $clog2(NDIGITS+1) bits, product 20 bits.
// CONFIGURATION
//  E_DIGIT_STREAMER_CRLF_EN defined: after last digit, emit 8'h0D then 8'h0A (each a handshake).
//   dout_last moves to the LF; then IDLE.
//  Not defined: stream ends at last digit with dout_last there; no CR/LF states synthesised.
// TESTING
//  1 WORDS=32, NDIGITS=20, in_data=e from calculator, dout_ready=1
//    -> "2.71828182845904523536", dout_last on final '6'.
//  2 int=0, fraction top word=16'h8000 (others 0), NDIGITS=4 -> "0.5000"; then in_ready=1.
//  3 Case 1 with dout_ready random ~50%
//    -> identical byte sequence; dout stable while valid&&!ready; no duplicated or dropped chars.
//  4 int=16'd12, fraction 16'h4000 top word, NDIGITS=3 -> "?.250".
//  5 in_valid pulsed with a different value during MUL
//    -> ignored, original stream completes unchanged; assert rst mid-EMIT -> dout_valid=0, in_ready=1 next cycle.
//  6 E_DIGIT_STREAMER_CRLF_EN, test 2 -> "0.5000",8'h0D,8'h0A; dout_last only on 8'h0A.

Source files
------------

// File: rtl/e_digit_streamer.sv
// e_digit_streamer: turns a captured fixed-point e value into an ASCII "I.ddd...d" byte stream.
// Define E_DIGIT_STREAMER_CRLF_EN to append CR/LF after the last digit.
module e_digit_streamer #(
  parameter int WORDS   = 32,
  parameter int NDIGITS = 150
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                in_valid_i,
  input  logic [16*WORDS-1:0] in_data_i,
  output logic                in_ready_o,
  output logic [7:0]          dout_o,
  output logic                dout_valid_o,
  input  logic                dout_ready_i,
  output logic                dout_last_o,
  output logic                busy_o
);

  localparam int IDX_W = (WORDS > 2) ? $clog2(WORDS) : 1;
  localparam int CNT_W = (NDIGITS > 1) ? $clog2(NDIGITS + 1) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 2);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NDIGITS - 1);

  typedef enum logic [2:0] {
    IDLE, INT, DOT, MUL, EMIT
`ifdef E_DIGIT_STREAMER_CRLF_EN
    , CR, LF
`endif
  } state_e;

  state_e                  state_q, state_d;
  logic [15:0]             int_q, int_d;
  logic [WORDS-2:0][15:0]  frac_q, frac_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [3:0]              carry_q, carry_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [19:0]             mulProd;
  logic                    handshake;

  // One fraction word times ten plus the carry from the word below; carry stays 0..9.
  assign mulProd   = 20'(frac_q[idx_q]) * 20'd10 + 20'(carry_q);
  assign handshake = dout_valid_o && dout_ready_i;
  assign in_ready_o = (state_q == IDLE);
  assign busy_o     = ~in_ready_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      int_q   <= '0;
      frac_q  <= '0;
      idx_q   <= '0;
      carry_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      int_q   <= int_d;
      frac_q  <= frac_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    int_d        = int_q;
    frac_d       = frac_q;
    idx_d        = idx_q;
    carry_d      = carry_q;
    cnt_d        = cnt_q;
    dout_o       = 8'h00;
    dout_valid_o = 1'b0;
    dout_last_o  = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          int_d   = in_data_i[16*WORDS-1 -: 16];
          frac_d  = in_data_i[16*WORDS-17:0];
          cnt_d   = '0;
          state_d = INT;
        end
      end
      INT: begin
        dout_valid_o = 1'b1;
        dout_o       = (int_q <= 16'd9) ? {4'h3, int_q[3:0]} : 8'h3F;
        if (handshake) state_d = DOT;
      end
      DOT: begin
        dout_valid_o = 1'b1;
        dout_o       = 8'h2E;
        if (handshake) begin
          idx_d   = '0;
          carry_d = '0;
          state_d = MUL;
        end
      end
      MUL: begin
        frac_d[idx_q] = mulProd[15:0];
        carry_d       = mulProd[19:16];
        idx_d         = idx_q + 1'b1;
        if (idx_q == LAST_IDX) state_d = EMIT;
      end
      EMIT: begin
        dout_valid_o = 1'b1;
        dout_o       = {4'h3, carry_q};
`ifndef E_DIGIT_STREAMER_CRLF_EN
        dout_last_o  = (cnt_q == LAST_CNT);
`endif
        if (handshake) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
`ifdef E_DIGIT_STREAMER_CRLF_EN
            state_d = CR;
`else
            state_d = IDLE;
`endif
          end else begin
            idx_d   = '0;
            carry_d = '0;
            state_d = MUL;
          end
        end
      end
`ifdef E_DIGIT_STREAMER_CRLF_EN
      CR: begin
        dout_valid_o = 1'b1;
        dout_o       = 8'h0D;
        if (handshake) state_d = LF;
      end
      LF: begin
        dout_valid_o = 1'b1;
        dout_o       = 8'h0A;
        dout_last_o  = 1'b1;
        if (handshake) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_e_digit_streamer.sv
// tb_e_digit_streamer: directed vectors on a small instance plus the full 32-word e stream.
// Expected text gains a CR/LF trailer when E_DIGIT_STREAMER_CRLF_EN is defined.
`timescale 1ns/1ps
module tb_e_digit_streamer;

  localparam int WORDS_E = 32;
  localparam int ND_E    = 20;
  localparam int WORDS_S = 4;
  localparam int ND_S    = 4;

  typedef struct {
    logic [15:0] intWord;
    logic [47:0] frac;
    string       text;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, doutReady, sel;
  logic inValidE, inValidS;
  logic [16*WORDS_E-1:0] inDataE;
  logic [16*WORDS_S-1:0] inDataS, pokeData;
  logic inReadyE, inReadyS, dvE, dvS, dlE, dlS, busyE, busyS;
  logic [7:0] doutE, doutS;
  logic inReady, dv, dl, busy;
  logic [7:0] dout;
  int testsRun = 0;
  int testsFailed = 0;

  assign inReady = sel ? inReadyE : inReadyS;
  assign dv      = sel ? dvE : dvS;
  assign dl      = sel ? dlE : dlS;
  assign busy    = sel ? busyE : busyS;
  assign dout    = sel ? doutE : doutS;

  e_digit_streamer #(.WORDS(WORDS_E), .NDIGITS(ND_E)) dutE (
    .clk_i(clk), .rst_i(rst), .in_valid_i(inValidE), .in_data_i(inDataE),
    .in_ready_o(inReadyE), .dout_o(doutE), .dout_valid_o(dvE),
    .dout_ready_i(doutReady), .dout_last_o(dlE), .busy_o(busyE));

  e_digit_streamer #(.WORDS(WORDS_S), .NDIGITS(ND_S)) dutS (
    .clk_i(clk), .rst_i(rst), .in_valid_i(inValidS), .in_data_i(inDataS),
    .in_ready_o(inReadyS), .dout_o(doutS), .dout_valid_o(dvS),
    .dout_ready_i(doutReady), .dout_last_o(dlS), .busy_o(busyS));

  function automatic string withTrailer(input string base);
`ifdef E_DIGIT_STREAMER_CRLF_EN
    return $sformatf("%s%c%c", base, 8'h0d, 8'h0a);
`else
    return base;
`endif
  endfunction

  function automatic string printable(input string s);
    string r;
    r = "";
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] == 8'h0d) r = {r, "<CR>"};
      else if (s[i] == 8'h0a) r = {r, "<LF>"};
      else r = {r, s.substr(i, i)};
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic checkText(input string name, input string got, input string expected);
    testsRun++;
    if (got != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got \"%s\", expected \"%s\"", name, printable(got), printable(expected));
    end
  endtask

  // Called on a falling edge with the small instance idle; returns on the falling edge where INT is shown.
  task automatic applyStimulus(input logic [15:0] intWord, input logic [47:0] frac);
    sel      = 1'b0;
    inDataS  = {intWord, frac};
    inValidS = 1'b1;
    @(negedge clk);
    inValidS = 1'b0;
    checkOutput("first char latency", {31'd0, dvS}, 32'd1);
  endtask

  task automatic collect(input int expLen, input int budget, input bit randReady,
                         input int pokeCycle, input bit holdAtEnd,
                         output string got, output int lastCount, output int lastPos,
                         output int stallErr);
    logic       stalled, prevLast, rdy;
    logic [7:0] prevDout;
    bit         done;
    got = ""; lastCount = 0; lastPos = -1; stallErr = 0;
    stalled = 1'b0; prevLast = 1'b0; prevDout = 8'h00; done = 1'b0;
    for (int cyc = 0; cyc < budget && !done; cyc++) begin
      if (pokeCycle == cyc) begin
        inValidS = 1'b1;
        inDataS  = pokeData;
      end else if (pokeCycle >= 0 && pokeCycle == cyc - 1) begin
        inValidS = 1'b0;
      end
      if (stalled && (!dv || dout !== prevDout || dl !== prevLast)) stallErr++;
      rdy = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
      doutReady = rdy;
      if (dv && rdy) begin
        got = $sformatf("%s%c", got, dout);
        if (dl) begin
          lastCount++;
          lastPos = got.len() - 1;
        end
        if (got.len() == expLen) begin
          done = 1'b1;
          if (holdAtEnd) begin
            inValidS = 1'b1;
            inDataS  = pokeData;
          end
        end
      end
      stalled  = dv && !rdy;
      prevDout = dout;
      prevLast = dl;
      @(negedge clk);
    end
    doutReady = 1'b1;
  endtask

  task automatic checkStream(input string name, input string expected, input bit randReady,
                             input int pokeCycle, input bit holdAtEnd);
    string got;
    int lastCount, lastPos, stallErr;
    collect(expected.len(), 3000, randReady, pokeCycle, holdAtEnd, got, lastCount, lastPos, stallErr);
    checkText({name, " text"}, got, expected);
    checkOutput({name, " last count"}, 32'(lastCount), 32'd1);
    checkOutput({name, " last position"}, 32'(lastPos), 32'(expected.len() - 1));
    checkOutput({name, " stall stability"}, 32'(stallErr), 32'd0);
    checkOutput({name, " valid drops after end"}, {31'd0, dv}, 32'd0);
    checkOutput({name, " ready after end"}, {31'd0, inReady}, 32'd1);
  endtask

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t vecs[9];
    logic [495:0] eFrac, term;
    logic [17:0] seen, expSeen;
    bit idleSeen;

    vecs[0] = '{16'd0,      48'h8000_0000_0000, "0.5000"};
    vecs[1] = '{16'd12,     48'h4000_0000_0000, "?.2500"};
    vecs[2] = '{16'd9,      48'h0000_0000_0000, "9.0000"};
    vecs[3] = '{16'd1,      48'hFFFF_FFFF_FFFF, "1.9999"};
    vecs[4] = '{16'd3,      48'h2000_0000_0000, "3.1250"};
    vecs[5] = '{16'd10,     48'h1999_9999_999A, "?.1000"};
    vecs[6] = '{16'd7,      48'hC000_0000_0000, "7.7500"};
    vecs[7] = '{16'd0,      48'h0000_0000_0001, "0.0000"};
    vecs[8] = '{16'hFFFF,   48'h8000_0000_0001, "?.5000"};

    // e - 2 as a 496-bit binary fraction from the series sum of 1/k!, k >= 2.
    eFrac = '0;
    term  = 496'd1 << 495;
    for (int k = 2; k < 200 && term != '0; k++) begin
      eFrac = eFrac + term;
      term  = term / 496'(k + 1);
    end

    sel = 1'b0; rst = 1'b1; doutReady = 1'b1;
    inValidE = 1'b0; inValidS = 1'b0; inDataE = '0; inDataS = '0; pokeData = '0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      checkOutput("reset in_ready", {31'd0, inReady}, 32'd1);
      checkOutput("reset dout", {24'd0, dout}, 32'd0);
      checkOutput("reset dout_valid", {31'd0, dv}, 32'd0);
      checkOutput("reset dout_last", {31'd0, dl}, 32'd0);
      checkOutput("reset busy", {31'd0, busy}, 32'd0);
    end
    sel = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].intWord, vecs[i].frac);
      checkOutput("busy while streaming", {31'd0, busy}, 32'd1);
      checkStream($sformatf("vec%0d", i), withTrailer(vecs[i].text), 1'b0, -1, 1'b0);
    end

    // Valid cadence: INT, DOT, then a digit every WORDS cycles.
    applyStimulus(16'd0, 48'h8000_0000_0000);
    for (int c = 0; c < 18; c++) begin
      seen[c]    = dvS;
      expSeen[c] = (c < 2) || (c >= WORDS_S + 1 && (c - 1) % WORDS_S == 0);
      @(negedge clk);
    end
    checkOutput("valid cadence", 32'(seen), 32'(expSeen));
    idleSeen = 1'b0;
    for (int c = 0; c < 20 && !idleSeen; c++) begin
      if (inReadyS) idleSeen = 1'b1;
      else @(negedge clk);
    end
    checkOutput("return to idle", {31'd0, idleSeen}, 32'd1);

    // A new value offered during MUL must be ignored.
    pokeData = {16'd7, 48'hFFFF_FFFF_FFFF};
    applyStimulus(16'd0, 48'h8000_0000_0000);
    checkStream("poke during MUL", withTrailer("0.5000"), 1'b0, 3, 1'b0);
    inValidS = 1'b0;

    // in_valid raised with the final handshake is taken one cycle later.
    pokeData = {16'd5, 48'hC000_0000_0000};
    applyStimulus(16'd3, 48'h2000_0000_0000);
    checkStream("hold at end", withTrailer("3.1250"), 1'b0, -1, 1'b1);
    @(negedge clk);
    inValidS = 1'b0;
    checkOutput("held value accepted", {31'd0, dvS}, 32'd1);
    checkOutput("held value int char", {24'd0, doutS}, 32'h35);
    checkStream("held value", withTrailer("5.7500"), 1'b0, -1, 1'b0);

    // Random back-pressure on the small instance.
    applyStimulus(16'd12, 48'h4000_0000_0000);
    checkStream("small random ready", withTrailer("?.2500"), 1'b1, -1, 1'b0);

    // Reset while showing the first digit.
    applyStimulus(16'd0, 48'h8000_0000_0000);
    repeat (WORDS_S + 1) @(negedge clk);
    checkOutput("emit before reset valid", {31'd0, dvS}, 32'd1);
    checkOutput("emit before reset digit", {24'd0, doutS}, 32'h35);
    doutReady = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid-stream reset dout_valid", {31'd0, dvS}, 32'd0);
    checkOutput("mid-stream reset in_ready", {31'd0, inReadyS}, 32'd1);
    checkOutput("mid-stream reset busy", {31'd0, busyS}, 32'd0);
    checkOutput("mid-stream reset dout_last", {31'd0, dlS}, 32'd0);
    checkOutput("mid-stream reset dout", {24'd0, doutS}, 32'd0);
    rst = 1'b0;
    doutReady = 1'b1;
    @(negedge clk);
    applyStimulus(16'd9, 48'h0000_0000_0000);
    checkStream("after reset", withTrailer("9.0000"), 1'b0, -1, 1'b0);

    // Full-width e, first with a always-ready sink, then with random back-pressure.
    for (int pass = 0; pass < 2; pass++) begin
      sel = 1'b1;
      inDataE  = {16'd2, eFrac};
      inValidE = 1'b1;
      @(negedge clk);
      inValidE = 1'b0;
      checkOutput("e first char latency", {31'd0, dvE}, 32'd1);
      checkStream(pass == 0 ? "e stream" : "e random ready",
                  withTrailer("2.71828182845904523536"), pass == 1, -1, 1'b0);
    end
    sel = 1'b0;

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
